// File: rtl/fetch_queue_if.sv
// Bundles the imem split handshake, redirect path and decode-side valid/ready
// of the fetch queue so they can be passed as a single port.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_addr_ok;
    logic        imem_data_ok;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_exception_instr;

    modport master (
        output imem_req, imem_addr,
        input  imem_addr_ok, imem_data_ok, imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc, out_pcplus4, out_exception_instr,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_addr_ok, imem_data_ok, imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc, out_pcplus4, out_exception_instr,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, keeps up to MAX_OUTSTANDING imem requests in
// flight and buffers returned words in a DEPTH-entry FIFO towards decode.
module fetch_queue #(
    parameter int          DEPTH           = 8,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hbfc0_0000
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]    r_pc;
    logic           r_halted;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_rdPtr;
    logic [AW-1:0]  r_wrPtr;
    logic [OW-1:0]  r_outstanding;
    logic [OW-1:0]  r_discard;
    logic [PW-1:0]  r_pendRd;
    logic [PW-1:0]  r_pendWr;
    logic [31:0]    r_instrMem [DEPTH];
    logic [31:0]    r_pcMem    [DEPTH];
    logic [DEPTH-1:0] r_excMem;
    logic [31:0]    r_pendPc   [MAX_OUTSTANDING];

    logic [OW-1:0]  w_live;
    logic [31:0]    w_slotsUsed;
    logic           w_fetchOk;
    logic           w_req;
    logic           w_accept;
    logic           w_respDrop;
    logic           w_respLive;
    logic           w_misalign;
    logic           w_outValid;
    logic           w_pop;
    logic           w_push;
    logic [31:0]    w_pushInstr;
    logic [31:0]    w_pushPc;
    logic [PW-1:0]  w_pendWrNext;
    logic [PW-1:0]  w_pendRdNext;

    // Live responses already own a FIFO slot, so count + live never exceeds DEPTH.
    assign w_live      = r_outstanding - r_discard;
    assign w_slotsUsed = 32'(r_count) + 32'(w_live);
    assign w_fetchOk   = !reset && !bus.redirect_valid && !r_halted;
    assign w_req       = w_fetchOk && (r_pc[1:0] == 2'b00)
                         && (32'(r_outstanding) < 32'(MAX_OUTSTANDING))
                         && (w_slotsUsed < 32'(DEPTH));
    assign w_accept    = w_req && bus.imem_addr_ok;
    assign w_respDrop  = bus.imem_data_ok && (r_discard != '0);
    assign w_respLive  = bus.imem_data_ok && (r_discard == '0);
    assign w_misalign  = w_fetchOk && (r_pc[1:0] != 2'b00) && (w_live == '0)
                         && (32'(r_count) < 32'(DEPTH));
    assign w_outValid  = !reset && (r_count != '0);
    assign w_pop       = w_outValid && bus.out_ready;
    assign w_push      = w_respLive || w_misalign;
    assign w_pushInstr = w_misalign ? 32'h0 : bus.imem_rdata;
    assign w_pushPc    = w_misalign ? r_pc : r_pendPc[r_pendRd];

    assign w_pendWrNext = (32'(r_pendWr) == 32'(MAX_OUTSTANDING - 1)) ? '0 : r_pendWr + PW'(1);
    assign w_pendRdNext = (32'(r_pendRd) == 32'(MAX_OUTSTANDING - 1)) ? '0 : r_pendRd + PW'(1);

    // A redirect keeps every in-flight request in the books but marks them stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_halted      <= 1'b0;
            r_count       <= '0;
            r_rdPtr       <= '0;
            r_wrPtr       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_pendRd      <= '0;
            r_pendWr      <= '0;
        end else if (bus.redirect_valid) begin
            r_pc          <= bus.redirect_pc;
            r_halted      <= 1'b0;
            r_count       <= '0;
            r_rdPtr       <= '0;
            r_wrPtr       <= '0;
            r_outstanding <= r_outstanding - OW'(bus.imem_data_ok);
            r_discard     <= r_outstanding - OW'(bus.imem_data_ok);
            r_pendRd      <= '0;
            r_pendWr      <= '0;
        end else begin
            if (w_accept) begin
                r_pc     <= r_pc + 32'd4;
                r_pendWr <= w_pendWrNext;
            end
            if (w_misalign) begin
                r_halted <= 1'b1;
            end
            if (w_respDrop) begin
                r_discard <= r_discard - OW'(1);
            end
            if (w_respLive) begin
                r_pendRd <= w_pendRdNext;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_outstanding <= r_outstanding + OW'(w_accept) - OW'(bus.imem_data_ok);
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= w_pushInstr;
            r_pcMem[r_wrPtr]    <= w_pushPc;
            r_excMem[r_wrPtr]   <= w_misalign;
        end
        if (w_accept) begin
            r_pendPc[r_pendWr] <= r_pc;
        end
    end

    assign bus.imem_req            = w_req;
    assign bus.imem_addr           = r_pc;
    assign bus.out_valid           = w_outValid;
    assign bus.out_instr           = w_outValid ? r_instrMem[r_rdPtr] : 32'h0;
    assign bus.out_pc              = w_outValid ? r_pcMem[r_rdPtr] : 32'h0;
    assign bus.out_pcplus4         = w_outValid ? r_pcMem[r_rdPtr] + 32'd4 : 32'h0;
    assign bus.out_exception_instr = w_outValid && r_excMem[r_rdPtr];
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model answers imem requests with
// rdata = address, and a monitor checks every entry decode consumes.
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam int MAXO  = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        exc;
    } entry_t;

    logic clk;
    logic reset;
    fetch_queue_if bus();

    entry_t      expQ[$];
    logic [31:0] respQ[$];
    logic [31:0] acceptLog[$];
    int grantsLeft = 0;
    int respBudget = 1000;
    int checks     = 0;
    int failures   = 0;

    fetch_queue #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC(32'hbfc0_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expectEntry(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] pcplus4, input logic exc);
        entry_t e;
        e.instr   = instr;
        e.pc      = pc;
        e.pcplus4 = pcplus4;
        e.exc     = exc;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic redirect, input logic [31:0] redirectPc, input logic ready);
        bus.redirect_valid = redirect;
        bus.redirect_pc    = redirectPc;
        bus.out_ready      = ready;
    endtask

    task automatic nextCycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory: accepts while grants remain, answers one cycle after acceptance.
    initial begin
        int owed;
        bus.imem_addr_ok = 1'b0;
        bus.imem_data_ok = 1'b0;
        bus.imem_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                respQ.delete();
                bus.imem_addr_ok = 1'b0;
                bus.imem_data_ok = 1'b0;
                bus.imem_rdata   = 32'h0;
            end else begin
                owed = respQ.size();
                if (owed > 0 && respBudget > 0) begin
                    bus.imem_data_ok = 1'b1;
                    bus.imem_rdata   = respQ.pop_front();
                    respBudget--;
                end else begin
                    bus.imem_data_ok = 1'b0;
                    bus.imem_rdata   = 32'h0;
                end
                assert (!(bus.imem_data_ok && owed == 0))
                    else $error("[TB] data_ok with nothing outstanding");
                bus.imem_addr_ok = (grantsLeft > 0);
                if (bus.imem_req && bus.imem_addr_ok) begin
                    respQ.push_back(bus.imem_addr);
                    acceptLog.push_back(bus.imem_addr);
                    grantsLeft--;
                end
            end
        end
    end

    // Monitor: every consumed head entry must match the oldest expectation.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && !bus.redirect_valid && bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected entry: got pc %h, expected none", bus.out_pc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_instr", bus.out_instr, e.instr);
                    checkOutput("out_pc", bus.out_pc, e.pc);
                    checkOutput("out_pcplus4", bus.out_pcplus4, e.pcplus4);
                    checkOutput("out_exception_instr", 32'(bus.out_exception_instr), 32'(e.exc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        nextCycle(3);
        checkOutput("reset imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post-reset imem_req", 32'(bus.imem_req), 32'd1);
        checkOutput("post-reset imem_addr", bus.imem_addr, 32'hbfc0_0000);
        checkOutput("post-reset out_instr", bus.out_instr, 32'h0);
        checkOutput("post-reset out_pc", bus.out_pc, 32'h0);
        checkOutput("post-reset out_pcplus4", bus.out_pcplus4, 32'h0);

        $display("[TB] streaming six words");
        for (int i = 0; i < 6; i++) begin
            expectEntry(32'hbfc0_0000 + 32'(4 * i), 32'hbfc0_0000 + 32'(4 * i),
                        32'hbfc0_0004 + 32'(4 * i), 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        grantsLeft = 6;
        nextCycle(2);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("stream valid %0d", i), 32'(bus.out_valid), 32'd1);
            nextCycle(1);
        end
        checkOutput("stream drained valid", 32'(bus.out_valid), 32'd0);
        checkOutput("stalled imem_req", 32'(bus.imem_req), 32'd1);
        checkOutput("stalled imem_addr", bus.imem_addr, 32'hbfc0_0018);
        checkOutput("stream accept count", 32'(acceptLog.size()), 32'd6);
        for (int i = 0; i < 6 && i < acceptLog.size(); i++) begin
            checkOutput($sformatf("stream addr %0d", i), acceptLog[i], 32'hbfc0_0000 + 32'(4 * i));
        end
        checkOutput("stream scoreboard empty", 32'(expQ.size()), 32'd0);

        $display("[TB] filling the queue with decode stalled");
        acceptLog.delete();
        applyStimulus(1'b0, 32'h0, 1'b0);
        grantsLeft = 100;
        nextCycle(20);
        checkOutput("full accept count", 32'(acceptLog.size()), 32'd8);
        checkOutput("full imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("full out_valid", 32'(bus.out_valid), 32'd1);
        grantsLeft = 0;
        for (int i = 0; i < 8; i++) begin
            expectEntry(32'hbfc0_0018 + 32'(4 * i), 32'hbfc0_0018 + 32'(4 * i),
                        32'hbfc0_001c + 32'(4 * i), 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle(1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("after pop imem_req", 32'(bus.imem_req), 32'd1);
        checkOutput("after pop imem_addr", bus.imem_addr, 32'hbfc0_0038);
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle(10);
        checkOutput("full drain scoreboard empty", 32'(expQ.size()), 32'd0);
        checkOutput("full drain out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] redirect with two requests in flight");
        respBudget = 0;
        grantsLeft = 2;
        nextCycle(4);
        checkOutput("max outstanding imem_req", 32'(bus.imem_req), 32'd0);
        applyStimulus(1'b1, 32'h8000_1000, 1'b1);
        expQ.delete();
        #1;
        checkOutput("redirect cycle imem_req", 32'(bus.imem_req), 32'd0);
        nextCycle(1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("post-redirect out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("post-redirect imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("post-redirect imem_addr", bus.imem_addr, 32'h8000_1000);
        expectEntry(32'h8000_1000, 32'h8000_1000, 32'h8000_1004, 1'b0);
        acceptLog.delete();
        respBudget = 1000;
        grantsLeft = 1;
        nextCycle(8);
        checkOutput("redirect scoreboard empty", 32'(expQ.size()), 32'd0);
        checkOutput("redirect fetch count", 32'(acceptLog.size()), 32'd1);

        $display("[TB] redirect coinciding with a response");
        respBudget = 0;
        grantsLeft = 2;
        nextCycle(4);
        respBudget = 1000;
        grantsLeft = 1;
        applyStimulus(1'b1, 32'h8000_2000, 1'b1);
        expQ.delete();
        expectEntry(32'h8000_2000, 32'h8000_2000, 32'h8000_2004, 1'b0);
        nextCycle(1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle(8);
        checkOutput("coincident redirect scoreboard empty", 32'(expQ.size()), 32'd0);

        $display("[TB] redirect to a misaligned pc");
        acceptLog.delete();
        applyStimulus(1'b1, 32'h8000_0002, 1'b1);
        grantsLeft = 5;
        expectEntry(32'h0, 32'h8000_0002, 32'h8000_0006, 1'b1);
        nextCycle(1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("misaligned imem_req", 32'(bus.imem_req), 32'd0);
        nextCycle(10);
        checkOutput("misaligned accept count", 32'(acceptLog.size()), 32'd0);
        checkOutput("misaligned scoreboard empty", 32'(expQ.size()), 32'd0);
        checkOutput("halted imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("halted out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] pcplus4 wrap at top of address space");
        applyStimulus(1'b1, 32'hffff_fffc, 1'b1);
        grantsLeft = 1;
        expectEntry(32'hffff_fffc, 32'hffff_fffc, 32'h0000_0000, 1'b0);
        nextCycle(1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle(6);
        checkOutput("wrap scoreboard empty", 32'(expQ.size()), 32'd0);
        checkOutput("wrap next imem_addr", bus.imem_addr, 32'h0);
        checkOutput("wrap accept count", 32'(acceptLog.size()), 32'd1);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 32'h8000_3000, 1'b0);
        grantsLeft = 7;
        respBudget = 5;
        nextCycle(1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        nextCycle(14);
        checkOutput("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre-reset imem_req", 32'(bus.imem_req), 32'd0);
        reset = 1'b1;
        expQ.delete();
        grantsLeft = 0;
        respBudget = 1000;
        #1;
        checkOutput("mid reset imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("mid reset out_valid", 32'(bus.out_valid), 32'd0);
        nextCycle(1);
        reset = 1'b0;
        #1;
        checkOutput("after reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("after reset imem_addr", bus.imem_addr, 32'hbfc0_0000);
        checkOutput("after reset imem_req", 32'(bus.imem_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            expectEntry(32'hbfc0_0000 + 32'(4 * i), 32'hbfc0_0000 + 32'(4 * i),
                        32'hbfc0_0004 + 32'(4 * i), 1'b0);
        end
        grantsLeft = 3;
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle(10);
        checkOutput("restart scoreboard empty", 32'(expQ.size()), 32'd0);
        checkOutput("restart imem_addr", bus.imem_addr, 32'hbfc0_000c);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
